// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared VGA mode timings, sync polarity values and the axis total helper
package vga_timing_pkg;
  localparam logic POL_NEG = 1'b0;
  localparam logic POL_POS = 1'b1;
  typedef struct packed {
    int active;
    int fp;
    int sync;
    int bp;
  } axis_t;
  localparam axis_t M640_H = '{640, 16, 96, 48};
  localparam axis_t M640_V = '{480, 10, 2, 33};
  localparam logic  M640_POL = POL_NEG;
  localparam axis_t M800_H = '{800, 40, 128, 88};
  localparam axis_t M800_V = '{600, 1, 4, 23};
  localparam logic  M800_POL = POL_POS;
  function automatic int total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction
endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis counter with wrap output and decodes of its next value
//   clk, rst_n   clock, asynchronous active-low reset (count presets to TOTAL-1)
//   i_inc        advance one position
//   o_wrap       advancing from TOTAL-1 back to 0 this cycle
//   o_nxt        count value after this cycle
//   o_is_act     o_nxt < ACTIVE
//   o_sync       sync pin level for o_nxt (POL inside the sync window, ~POL outside)
//   o_at_zero    o_nxt == 0
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int   TOTAL  = 800,
  parameter int   ACTIVE = 640,
  parameter int   FP     = 16,
  parameter int   SYNC   = 96,
  parameter logic POL    = POL_NEG,
  parameter int   W      = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  output logic         o_wrap,
  output logic [W-1:0] o_nxt,
  output logic         o_is_act,
  output logic         o_sync,
  output logic         o_at_zero
);
  // One extra bit so a sync window ending exactly at 2**W still compares correctly
  localparam logic [W:0] L_LAST = (W+1)'(TOTAL - 1);
  localparam logic [W:0] L_ACT  = (W+1)'(ACTIVE);
  localparam logic [W:0] L_S0   = (W+1)'(ACTIVE + FP);
  localparam logic [W:0] L_S1   = (W+1)'(ACTIVE + FP + SYNC);
  logic [W-1:0] r_cnt;
  if (TOTAL < 1 || TOTAL > 2**W) begin : g_range
    $error("vga_axis_counter: TOTAL %0d does not fit in %0d bits", TOTAL, W);
  end
  assign o_wrap    = i_inc && {1'b0, r_cnt} == L_LAST;
  assign o_nxt     = o_wrap ? '0 : r_cnt + W'(i_inc);
  assign o_is_act  = {1'b0, o_nxt} < L_ACT;
  assign o_sync    = ({1'b0, o_nxt} >= L_S0 && {1'b0, o_nxt} < L_S1) ? POL : ~POL;
  assign o_at_zero = o_nxt == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= L_LAST[W-1:0];
    else r_cnt <= o_nxt;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator with pixel clock-enable divider
//   clk, rst_n   system clock, asynchronous active-low reset
//   en           run; 0 freezes divider, counters and outputs
//   pixCe        1-clk pulse every CE_DIV clks while en=1
//   HS, VS       sync pins, polarity HS_POL / VS_POL
//   hPix, vPix   active-area coordinates, 0 outside the visible area
//   isActive     current pixel is visible
//   lineStart    1-clk pulse as the position enters h=0
//   frameStart   1-clk pulse as the position enters (0,0)
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = M640_H.active,
  parameter int   H_FP     = M640_H.fp,
  parameter int   H_SYNC   = M640_H.sync,
  parameter int   H_BP     = M640_H.bp,
  parameter int   V_ACTIVE = M640_V.active,
  parameter int   V_FP     = M640_V.fp,
  parameter int   V_SYNC   = M640_V.sync,
  parameter int   V_BP     = M640_V.bp,
  parameter logic HS_POL   = M640_POL,
  parameter logic VS_POL   = M640_POL,
  parameter int   CE_DIV   = 2,
  parameter int   HW       = 10,
  parameter int   VW       = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic          pixCe,
  output logic          HS,
  output logic          VS,
  output logic [HW-1:0] hPix,
  output logic [VW-1:0] vPix,
  output logic          isActive,
  output logic          lineStart,
  output logic          frameStart
);
  localparam int DW = CE_DIV > 1 ? $clog2(CE_DIV) : 1;
  localparam logic [DW-1:0] L_DIV_LAST = DW'(CE_DIV - 1);
  logic [DW-1:0] r_div;
  logic          w_h_wrap, w_h_act, w_hs, w_h0;
  logic          w_v_wrap, w_v_act, w_vs, w_v0;
  logic [HW-1:0] w_h;
  logic [VW-1:0] w_v;
  if (CE_DIV < 1) begin : g_div_range
    $error("vga_timing_gen: CE_DIV %0d must be >= 1", CE_DIV);
  end
  // Gated by rst_n so the pulse also drops asynchronously when CE_DIV=1
  assign pixCe = en && rst_n && r_div == L_DIV_LAST;
  vga_axis_counter #(
    .TOTAL(total(H_ACTIVE, H_FP, H_SYNC, H_BP)), .ACTIVE(H_ACTIVE), .FP(H_FP),
    .SYNC(H_SYNC), .POL(HS_POL), .W(HW)
  ) u_h (
    .clk(clk), .rst_n(rst_n), .i_inc(pixCe), .o_wrap(w_h_wrap), .o_nxt(w_h),
    .o_is_act(w_h_act), .o_sync(w_hs), .o_at_zero(w_h0)
  );
  vga_axis_counter #(
    .TOTAL(total(V_ACTIVE, V_FP, V_SYNC, V_BP)), .ACTIVE(V_ACTIVE), .FP(V_FP),
    .SYNC(V_SYNC), .POL(VS_POL), .W(VW)
  ) u_v (
    .clk(clk), .rst_n(rst_n), .i_inc(pixCe && w_h_wrap), .o_wrap(w_v_wrap), .o_nxt(w_v),
    .o_is_act(w_v_act), .o_sync(w_vs), .o_at_zero(w_v0)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_div      <= '0;
      HS         <= ~HS_POL;
      VS         <= ~VS_POL;
      hPix       <= '0;
      vPix       <= '0;
      isActive   <= 1'b0;
      lineStart  <= 1'b0;
      frameStart <= 1'b0;
    end else begin
      if (en) r_div <= pixCe ? '0 : r_div + DW'(1);
      lineStart  <= pixCe && w_h0;
      frameStart <= w_v_wrap && w_v0;
      if (pixCe) begin
        HS       <= w_hs;
        VS       <= w_vs;
        isActive <= w_h_act && w_v_act;
        hPix     <= (w_h_act && w_v_act) ? w_h : '0;
        vPix     <= (w_h_act && w_v_act) ? w_v : '0;
      end
    end
endmodule
